pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Game-flow controller for the two-player pong display. Sequences the ball/paddle graphics block through new-game, serve, play and game-over phases by driving its `graph_still` freeze input. Consumes its per-frame hit/miss events and keeps per-player BCD scores, serve and game-over delays, and audio trigger pulses. Sits between the VGA sync counters and the graphics/text overlay in the pong top level.

## Interface
- `SERVE_TICKS`, default 120: refresh ticks (60 Hz frames) held frozen before each serve (2 s).
- `OVER_TICKS`, default 180: refresh ticks held on the game-over screen before returning to new-game.
- `WIN_BCD`, default 8'h11: winning score, two BCD digits.
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high.
- `pix_x`, input, 10: current pixel column from the sync generator.
- `pix_y`, input, 10: current pixel row from the sync generator.
- `btn1`, input, 2: player-1 paddle buttons; any bit high counts as "press".
- `btn2`, input, 2: player-2 paddle buttons.
- `hit`, input, 1: ball hit a paddle, 1-cycle pulse from graphics.
- `miss_left`, input, 1: ball passed the left paddle, 1-cycle pulse; point to right player.
- `miss_right`, input, 1: ball passed the right paddle, 1-cycle pulse; point to left player.
- `graph_still`, output, 1: freeze/recentre ball and paddles.
- `game_state`, output, 2: 0 NEWGAME, 1 NEWBALL, 2 PLAY, 3 OVER (for the text overlay).
- `score_l`, output, 8: left-player score, two BCD digits.
- `score_r`, output, 8: right-player score, two BCD digits.
- `winner`, output, 2: 0 none, 1 left, 2 right.
- `hit_snd`, output, 1: 1-cycle pulse per accepted hit.
- `miss_snd`, output, 1: 1-cycle pulse per accepted miss.
- `speed_lvl`, output, 2: ball speed level for the graphics block.

## Operation
- `refr_tick` is decoded combinationally as `pix_y == 481 && pix_x == 0`. It fires once per frame.
- Delay timer, 8 bits:
  - A load in a state transition sets it to `SERVE_TICKS` or `OVER_TICKS`.
  - It decrements only on `refr_tick` while nonzero.
  - `timer_up` is `timer == 0`.
- FSM:
  - NEWGAME (reset state): `graph_still=1`. Any `btn1`/`btn2` bit high clears both scores and `winner`, loads `SERVE_TICKS`, and goes to NEWBALL.
  - NEWBALL: `graph_still=1`. When `timer_up`, go to PLAY.
  - PLAY: `graph_still=0`.
    - An accepted miss adds 1 (BCD, units 9→0 carries to tens) to the opposing score and pulses `miss_snd`.
    - If the post-increment score equals `WIN_BCD`, set `winner`, load `OVER_TICKS`, and go to OVER.
    - Otherwise load `SERVE_TICKS` and go to NEWBALL.
  - OVER: `graph_still=1`. When `timer_up`, go to NEWGAME. Scores and `winner` stay held until the next start press.
- Priority in PLAY: `miss_left` > `miss_right` > `hit`.
  - Simultaneous misses award exactly one point, to the right player.
  - A hit coincident with a miss is dropped, with no `hit_snd`.
- `hit`, `miss_left` and `miss_right` are ignored outside PLAY.
- Score saturates at 8'h99; no wrap to 00.

## Timing
- Reset values: state NEWGAME, `graph_still=1`, `game_state=0`, `score_l=score_r=0`, `winner=0`, `hit_snd=miss_snd=0`, `speed_lvl=0`, timer 0, hit counter 0.
- All outputs are registered or decoded from registered state. Event-to-output latency is 1 cycle: score, `snd` pulses and state all update on the edge after the input pulse.
- `graph_still` rises on the edge that leaves PLAY. It falls on the edge where NEWBALL sees `timer_up`.
- Serve delay: exactly `SERVE_TICKS` `refr_tick` events after entry, plus up to 1 cycle.
- Reset mid-game returns asynchronously to NEWGAME with all values above, regardless of the current state.

## Configuration
- Macro `PONG_CTRL_SPEEDUP_EN` defined:
  - A 4-bit hit counter counts accepted hits in PLAY and clears on every entry to NEWBALL.
  - `speed_lvl` = min(counter/4, 3), registered.
  - The counter saturates at 15.
- Macro undefined: no hit counter; `speed_lvl` is tied to 0. `hit_snd` behaviour is unchanged.

## Structure
- Package `pong_pkg`:
  - state encoding constants NEWGAME/NEWBALL/PLAY/OVER;
  - winner codes;
  - `REFR_Y = 481`;
  - default tick counts.
  - The graphics and text blocks share the state encoding from here.
- Sub-module `bcd_cnt2`: 2-digit saturating BCD counter with `clr`/`inc`, instantiated twice, for left and right scores.
- The FSM, timer and speed-up logic stay in `pong_game_ctrl`.

## Test plan
- Reset, then press `btn1[0]` for 1 cycle → NEWBALL; after 120 `refr_tick`s → PLAY, `graph_still=0`.
- In PLAY, pulse `miss_right` → `score_l` 8'h01, `miss_snd` one cycle, state NEWBALL, `graph_still=1` next cycle.
- Preload `score_l` to 8'h09 via 9 misses, then one more `miss_right` → `score_l` 8'h10 (BCD carry). At 8'h10, one more → 8'h11 = `WIN_BCD` → OVER, `winner=1`; after 180 ticks → NEWGAME with scores held; next press clears them to 0.
- Same cycle `miss_left`, `miss_right` and `hit` → only `score_r` +1, one `miss_snd`, no `hit_snd`.
- With `PONG_CTRL_SPEEDUP_EN` defined, 8 hits in PLAY → `speed_lvl=2`; a subsequent miss, then the serve → `speed_lvl=0`.
- Assert `reset` during OVER mid-delay → immediately NEWGAME, scores 0, `winner=0`, `graph_still=1`.

Source files
------------

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================
// pong_pkg - shared game-state encoding, winner codes, timing
// Revision: 1.0
// ============================================================
package pong_pkg;

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    NEWBALL = 2'd1,
    PLAY    = 2'd2,
    OVER    = 2'd3
  } game_state_t;

  localparam logic [1:0] WIN_NONE  = 2'd0;
  localparam logic [1:0] WIN_LEFT  = 2'd1;
  localparam logic [1:0] WIN_RIGHT = 2'd2;

  localparam int REFR_Y          = 481;
  localparam int REFR_X          = 0;
  localparam int DEF_SERVE_TICKS = 120;
  localparam int DEF_OVER_TICKS  = 180;

  localparam logic [7:0] BCD_MAX = 8'h99;

  // Two-digit BCD increment that holds at 99 instead of wrapping.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == BCD_MAX)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_cnt2.sv
`default_nettype none
// ============================================================
// bcd_cnt2 - two-digit saturating BCD counter with clear/inc
// Revision: 1.0
// ============================================================
module bcd_cnt2
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);

  logic [7:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_count <= 8'h00;
    else if (clr)
      r_count <= 8'h00;
    else if (inc)
      r_count <= bcd_inc_sat(r_count);
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================
// pong_game_ctrl - pong game-flow FSM, serve/over delays, scores
// Optional PONG_CTRL_SPEEDUP_EN: hit counter drives speed_lvl.
// Revision: 1.0
// ============================================================
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int         SERVE_TICKS = DEF_SERVE_TICKS,
  parameter int         OVER_TICKS  = DEF_OVER_TICKS,
  parameter logic [7:0] WIN_BCD     = 8'h11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [1:0] btn1,
  input  logic [1:0] btn2,
  input  logic       hit,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       graph_still,
  output logic [1:0] game_state,
  output logic [7:0] score_l,
  output logic [7:0] score_r,
  output logic [1:0] winner,
  output logic       hit_snd,
  output logic       miss_snd,
  output logic [1:0] speed_lvl
);

  localparam logic [7:0] C_SERVE_LOAD = 8'(SERVE_TICKS);
  localparam logic [7:0] C_OVER_LOAD  = 8'(OVER_TICKS);

  game_state_t r_state;
  logic [7:0]  r_timer;
  logic        r_still;
  logic [1:0]  r_winner;
  logic        r_hit_snd;
  logic        r_miss_snd;

  logic       w_refr_tick;
  logic       w_timer_up;
  logic       w_press;
  logic       w_in_play;
  logic       w_pt_left;
  logic       w_pt_right;
  logic       w_hit_ok;
  logic       w_clr;
  logic [7:0] w_score_l;
  logic [7:0] w_score_r;
  logic       w_win_l;
  logic       w_win_r;

  assign w_refr_tick = (pix_y == 10'(REFR_Y)) && (pix_x == 10'(REFR_X));
  assign w_timer_up  = (r_timer == 8'd0);
  assign w_press     = (|btn1) | (|btn2);
  assign w_in_play   = (r_state == PLAY);

  // miss_left outranks miss_right, and any miss swallows a coincident hit.
  assign w_pt_right = w_in_play & miss_left;
  assign w_pt_left  = w_in_play & miss_right & ~miss_left;
  assign w_hit_ok   = w_in_play & hit & ~miss_left & ~miss_right;
  assign w_clr      = (r_state == NEWGAME) & w_press;

  assign w_win_l = w_pt_left  && (bcd_inc_sat(w_score_l) == WIN_BCD);
  assign w_win_r = w_pt_right && (bcd_inc_sat(w_score_r) == WIN_BCD);

  bcd_cnt2 u_score_l (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .inc   (w_pt_left),
    .count (w_score_l)
  );

  bcd_cnt2 u_score_r (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .inc   (w_pt_right),
    .count (w_score_r)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= NEWGAME;
      r_timer    <= 8'd0;
      r_still    <= 1'b1;
      r_winner   <= WIN_NONE;
      r_hit_snd  <= 1'b0;
      r_miss_snd <= 1'b0;
    end else begin
      r_hit_snd  <= w_hit_ok;
      r_miss_snd <= w_pt_left | w_pt_right;
      // A load below overrides this tick decrement.
      if (w_refr_tick && !w_timer_up)
        r_timer <= r_timer - 8'd1;
      case (r_state)
        NEWGAME: begin
          if (w_press) begin
            r_winner <= WIN_NONE;
            r_timer  <= C_SERVE_LOAD;
            r_state  <= NEWBALL;
          end
        end
        NEWBALL: begin
          if (w_timer_up) begin
            r_still <= 1'b0;
            r_state <= PLAY;
          end
        end
        PLAY: begin
          if (w_pt_left || w_pt_right) begin
            r_still <= 1'b1;
            if (w_win_r) begin
              r_winner <= WIN_RIGHT;
              r_timer  <= C_OVER_LOAD;
              r_state  <= OVER;
            end else if (w_win_l) begin
              r_winner <= WIN_LEFT;
              r_timer  <= C_OVER_LOAD;
              r_state  <= OVER;
            end else begin
              r_timer  <= C_SERVE_LOAD;
              r_state  <= NEWBALL;
            end
          end
        end
        OVER: begin
          if (w_timer_up)
            r_state <= NEWGAME;
        end
        default: r_state <= NEWGAME;
      endcase
    end
  end

`ifdef PONG_CTRL_SPEEDUP_EN
  logic       w_serve_entry;
  logic [3:0] r_hit_cnt;
  logic [3:0] w_hit_cnt_nxt;
  logic [1:0] r_speed_lvl;

  assign w_serve_entry = w_clr | ((w_pt_left | w_pt_right) & ~(w_win_l | w_win_r));

  always_comb begin
    w_hit_cnt_nxt = r_hit_cnt;
    if (w_serve_entry)
      w_hit_cnt_nxt = 4'd0;
    else if (w_hit_ok && (r_hit_cnt != 4'hF))
      w_hit_cnt_nxt = r_hit_cnt + 4'd1;
  end

  // Level tracks the next count so it moves on the same edge as the hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_cnt   <= 4'd0;
      r_speed_lvl <= 2'd0;
    end else begin
      r_hit_cnt   <= w_hit_cnt_nxt;
      r_speed_lvl <= w_hit_cnt_nxt[3:2];
    end
  end

  assign speed_lvl = r_speed_lvl;
`else
  assign speed_lvl = 2'd0;
`endif

  assign graph_still = r_still;
  assign game_state  = r_state;
  assign score_l     = w_score_l;
  assign score_r     = w_score_r;
  assign winner      = r_winner;
  assign hit_snd     = r_hit_snd;
  assign miss_snd    = r_miss_snd;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================
// tb_pong_game_ctrl - directed and randomized checks of the pong controller
// Revision: 1.0
// ============================================================
module tb_pong_game_ctrl;

  localparam int         C_SERVE = 120;
  localparam int         C_OVER  = 180;
  localparam logic [7:0] C_WIN   = 8'h11;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pix_x, pix_y;
  logic [1:0] btn1, btn2;
  logic       hit, miss_left, miss_right;
  logic       graph_still, hit_snd, miss_snd;
  logic [1:0] game_state, winner, speed_lvl;
  logic [7:0] score_l, score_r;

  // second instance, short delays and unreachable win score, for saturation
  logic [1:0] s_btn;
  logic       s_mr;
  logic [9:0] s_pix_y;
  logic [9:0] s_pix_x = 10'd0;
  logic [1:0] s_zero2 = 2'd0;
  logic       s_zero = 1'b0;
  logic       s_still, s_hit_snd, s_miss_snd;
  logic [1:0] s_state, s_winner, s_speed;
  logic [7:0] s_score_l, s_score_r;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: plain integers, scores kept in decimal
  int m_phase, m_timer, m_sl, m_sr, m_win, m_hits;
  bit m_hit_snd, m_miss_snd;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .btn1(btn1), .btn2(btn2), .hit(hit), .miss_left(miss_left), .miss_right(miss_right),
    .graph_still(graph_still), .game_state(game_state), .score_l(score_l), .score_r(score_r),
    .winner(winner), .hit_snd(hit_snd), .miss_snd(miss_snd), .speed_lvl(speed_lvl)
  );

  pong_game_ctrl #(.SERVE_TICKS(1), .OVER_TICKS(1), .WIN_BCD(8'hFF)) dut_sat (
    .clk(clk), .reset(reset), .pix_x(s_pix_x), .pix_y(s_pix_y),
    .btn1(s_btn), .btn2(s_zero2), .hit(s_zero), .miss_left(s_zero), .miss_right(s_mr),
    .graph_still(s_still), .game_state(s_state), .score_l(s_score_l), .score_r(s_score_r),
    .winner(s_winner), .hit_snd(s_hit_snd), .miss_snd(s_miss_snd), .speed_lvl(s_speed)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic [1:0] exp_speed();
`ifdef PONG_CTRL_SPEEDUP_EN
    return (m_hits / 4 > 3) ? 2'd3 : 2'(m_hits / 4);
`else
    return 2'd0;
`endif
  endfunction

  task automatic model_reset();
    m_phase = 0; m_timer = 0; m_sl = 0; m_sr = 0; m_win = 0; m_hits = 0;
    m_hit_snd = 0; m_miss_snd = 0;
  endtask

  // Advances the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int  old_t;
    bit  refr;
    old_t = m_timer;
    refr = (pix_y == 10'd481) && (pix_x == 10'd0);
    m_hit_snd = 0;
    m_miss_snd = 0;
    if (refr && m_timer > 0) m_timer--;
    case (m_phase)
      0: if (btn1 != 0 || btn2 != 0) begin
           m_sl = 0; m_sr = 0; m_win = 0; m_hits = 0; m_timer = C_SERVE; m_phase = 1;
         end
      1: if (old_t == 0) m_phase = 2;
      2: if (miss_left || miss_right) begin
           int sc;
           m_miss_snd = 1;
           if (miss_left) begin if (m_sr < 99) m_sr++; sc = m_sr; end
           else begin if (m_sl < 99) m_sl++; sc = m_sl; end
           if (to_bcd(sc) == C_WIN) begin
             m_win = miss_left ? 2 : 1; m_timer = C_OVER; m_phase = 3;
           end else begin
             m_timer = C_SERVE; m_hits = 0; m_phase = 1;
           end
         end else if (hit) begin
           m_hit_snd = 1;
           if (m_hits < 15) m_hits++;
         end
      default: if (old_t == 0) m_phase = 0;
    endcase
  endtask

  // Apply inputs at a falling edge, run one rising edge, return at the next falling edge.
  task automatic drive(input logic [1:0] b1, input logic [1:0] b2,
                       input logic h, input logic ml, input logic mr, input logic rf);
    btn1 = b1; btn2 = b2; hit = h; miss_left = ml; miss_right = mr;
    if (rf) begin
      pix_x = 10'd0; pix_y = 10'd481;
    end else begin
      case ($urandom_range(0, 2))
        0: begin pix_x = 10'd1; pix_y = 10'd481; end
        1: begin pix_x = 10'd0; pix_y = 10'd480; end
        default: begin pix_x = 10'($urandom_range(0, 799)); pix_y = 10'($urandom_range(0, 480)); end
      endcase
    end
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic serve();
    repeat (C_SERVE) drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1; btn1 = 0; btn2 = 0; hit = 0; miss_left = 0; miss_right = 0;
    pix_x = 0; pix_y = 0; s_btn = 0; s_mr = 0; s_pix_y = 0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (game_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", game_state); end
    n_cmp++; if (graph_still !== 1'b1) begin n_bad++; $display("FAIL reset_still: got %b want 1", graph_still); end
    n_cmp++; if (score_l !== 8'h00 || score_r !== 8'h00) begin n_bad++; $display("FAIL reset_scores: got %h/%h want 00/00", score_l, score_r); end
    n_cmp++; if (winner !== 2'd0 || hit_snd !== 1'b0 || miss_snd !== 1'b0 || speed_lvl !== 2'd0) begin
      n_bad++; $display("FAIL reset_misc: winner=%0d hit_snd=%b miss_snd=%b speed=%0d want all 0", winner, hit_snd, miss_snd, speed_lvl); end
    drive(2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (game_state !== 2'd0 || score_r !== 8'h00 || miss_snd !== 1'b0 || hit_snd !== 1'b0) begin
      n_bad++; $display("FAIL newgame_ignores_events: state=%0d score_r=%h miss_snd=%b hit_snd=%b want 0/00/0/0", game_state, score_r, miss_snd, hit_snd); end
  endtask

  task automatic test_serve();
    drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (game_state !== 2'd1 || graph_still !== 1'b1) begin n_bad++; $display("FAIL press_to_newball: state=%0d still=%b want 1/1", game_state, graph_still); end
    repeat (C_SERVE - 1) begin
      drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
    end
    n_cmp++; if (game_state !== 2'd1) begin n_bad++; $display("FAIL serve_early: state=%0d want 1 after 119 ticks", game_state); end
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (game_state !== 2'd1) begin n_bad++; $display("FAIL serve_last_tick: state=%0d want 1", game_state); end
    idle();
    n_cmp++; if (game_state !== 2'd2 || graph_still !== 1'b0) begin n_bad++; $display("FAIL serve_play: state=%0d still=%b want 2/0", game_state, graph_still); end
  endtask

  task automatic test_miss_point();
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (score_l !== 8'h01 || score_r !== 8'h00) begin n_bad++; $display("FAIL miss_right_score: got %h/%h want 01/00", score_l, score_r); end
    n_cmp++; if (miss_snd !== 1'b1 || game_state !== 2'd1 || graph_still !== 1'b1) begin
      n_bad++; $display("FAIL miss_right_flow: miss_snd=%b state=%0d still=%b want 1/1/1", miss_snd, game_state, graph_still); end
    drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (miss_snd !== 1'b0 || hit_snd !== 1'b0 || score_l !== 8'h01) begin
      n_bad++; $display("FAIL newball_ignores_events: miss_snd=%b hit_snd=%b score_l=%h want 0/0/01", miss_snd, hit_snd, score_l); end
    serve();
  endtask

  task automatic test_bcd_carry_and_win();
    repeat (8) begin
      drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      serve();
    end
    n_cmp++; if (score_l !== 8'h09) begin n_bad++; $display("FAIL preload_09: got %h want 09", score_l); end
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (score_l !== 8'h10 || game_state !== 2'd1) begin n_bad++; $display("FAIL bcd_carry: score_l=%h state=%0d want 10/1", score_l, game_state); end
    serve();
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (score_l !== 8'h11 || game_state !== 2'd3 || winner !== 2'd1 || graph_still !== 1'b1) begin
      n_bad++; $display("FAIL win_left: score_l=%h state=%0d winner=%0d still=%b want 11/3/1/1", score_l, game_state, winner, graph_still); end
    repeat (C_OVER) drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (game_state !== 2'd3) begin n_bad++; $display("FAIL over_hold: state=%0d want 3", game_state); end
    idle();
    n_cmp++; if (game_state !== 2'd0 || score_l !== 8'h11 || winner !== 2'd1) begin
      n_bad++; $display("FAIL over_to_newgame: state=%0d score_l=%h winner=%0d want 0/11/1", game_state, score_l, winner); end
    drive(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (score_l !== 8'h00 || score_r !== 8'h00 || winner !== 2'd0 || game_state !== 2'd1) begin
      n_bad++; $display("FAIL restart_clear: %h/%h winner=%0d state=%0d want 00/00/0/1", score_l, score_r, winner, game_state); end
    serve();
  endtask

  task automatic test_simultaneous();
    drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (hit_snd !== 1'b1 || game_state !== 2'd2) begin n_bad++; $display("FAIL hit_alone: hit_snd=%b state=%0d want 1/2", hit_snd, game_state); end
    drive(2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (score_r !== 8'h01 || score_l !== 8'h00) begin n_bad++; $display("FAIL simul_score: got %h/%h want 00/01", score_l, score_r); end
    n_cmp++; if (miss_snd !== 1'b1 || hit_snd !== 1'b0) begin n_bad++; $display("FAIL simul_snd: miss_snd=%b hit_snd=%b want 1/0", miss_snd, hit_snd); end
    idle();
    n_cmp++; if (miss_snd !== 1'b0) begin n_bad++; $display("FAIL miss_snd_pulse: got %b want 0", miss_snd); end
    serve();
  endtask

  task automatic test_speedup();
    logic [1:0] want;
`ifdef PONG_CTRL_SPEEDUP_EN
    want = 2'd2;
`else
    want = 2'd0;
`endif
    repeat (8) drive(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (speed_lvl !== want || hit_snd !== 1'b1) begin n_bad++; $display("FAIL speed_after_8_hits: speed=%0d hit_snd=%b want %0d/1", speed_lvl, hit_snd, want); end
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    serve();
    n_cmp++; if (speed_lvl !== 2'd0 || score_l !== 8'h01) begin n_bad++; $display("FAIL speed_after_serve: speed=%0d score_l=%h want 0/01", speed_lvl, score_l); end
  endtask

  task automatic test_reset_mid_over();
    repeat (9) begin
      drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      serve();
    end
    drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (game_state !== 2'd3 || winner !== 2'd2 || score_r !== 8'h11) begin
      n_bad++; $display("FAIL win_right: state=%0d winner=%0d score_r=%h want 3/2/11", game_state, winner, score_r); end
    repeat (50) drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (game_state !== 2'd0 || score_l !== 8'h00 || score_r !== 8'h00 || winner !== 2'd0 || graph_still !== 1'b1) begin
      n_bad++; $display("FAIL async_reset: state=%0d %h/%h winner=%0d still=%b want 0/00/00/0/1", game_state, score_l, score_r, winner, graph_still); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 12000; i++) begin
      logic [1:0] b1, b2;
      b1 = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
      b2 = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
      drive(b1, b2, ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0));
      n_cmp++; if (game_state !== 2'(m_phase) || graph_still !== (m_phase != 2)) begin
        n_bad++; $display("FAIL rand_state cyc %0d: state=%0d still=%b want %0d/%b", i, game_state, graph_still, m_phase, (m_phase != 2)); end
      n_cmp++; if (score_l !== to_bcd(m_sl) || score_r !== to_bcd(m_sr) || winner !== 2'(m_win)) begin
        n_bad++; $display("FAIL rand_score cyc %0d: %h/%h winner=%0d want %h/%h/%0d", i, score_l, score_r, winner, to_bcd(m_sl), to_bcd(m_sr), m_win); end
      n_cmp++; if (hit_snd !== m_hit_snd || miss_snd !== m_miss_snd || speed_lvl !== exp_speed()) begin
        n_bad++; $display("FAIL rand_out cyc %0d: hit_snd=%b miss_snd=%b speed=%0d want %b/%b/%0d", i, hit_snd, miss_snd, speed_lvl, m_hit_snd, m_miss_snd, exp_speed()); end
    end
  endtask

  task automatic test_saturation();
    s_btn = 2'b01; @(negedge clk); s_btn = 2'b00;
    for (int i = 1; i <= 105; i++) begin
      s_pix_y = 10'd481; @(negedge clk);
      s_pix_y = 10'd0;   @(negedge clk);
      s_mr = 1'b1;       @(negedge clk);
      s_mr = 1'b0;
      if (i == 98) begin
        n_cmp++; if (s_score_l !== 8'h98) begin n_bad++; $display("FAIL sat_98: got %h want 98", s_score_l); end
      end
    end
    n_cmp++; if (s_score_l !== 8'h99 || s_state !== 2'd1 || s_winner !== 2'd0) begin
      n_bad++; $display("FAIL sat_99: score=%h state=%0d winner=%0d want 99/1/0", s_score_l, s_state, s_winner); end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_miss_point();
    test_bcd_carry_and_win();
    test_simultaneous();
    test_speedup();
    test_reset_mid_over();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
